// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side word/error FIFO between UART receiver and host read port
//
// Ports:
//   SysClk        system clock, all logic on posedge
//   Rst           asynchronous active-low reset
//   Rx_Valid      1-cycle pulse from receiver: Rx_Data/Rx_Error_In complete
//   Rx_Data       received word
//   Rx_Error_In   {frame,parity,break} for that word, stored verbatim
//   Read_Done     host strobe; rising edge loads the next entry onto the outputs
//   Data_Out      registered head word (last popped entry)
//   Rx_Error      registered error bits belonging to Data_Out
//   Data_Rdy      storage non-empty
//   FIFO_Empty    no stored entries
//   FIFO_Full     FIFO_DEPTH stored entries
//   FIFO_Overflow sticky: a write was dropped; cleared by the next effective pop
//   FIFO_Count    stored entries, 0..FIFO_DEPTH
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          SysClk,
    input  logic                          Rst,
    input  logic                          Rx_Valid,
    input  logic [DATA_BITS-1:0]          Rx_Data,
    input  logic [2:0]                    Rx_Error_In,
    input  logic                          Read_Done,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic [2:0]                    Rx_Error,
    output logic                          Data_Rdy,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 3;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty_q, full_q, ovf_q, ovf_d;
    logic                 rd_done_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           err_q, err_d;

    logic pop_req;
    logic pop_en;
    logic wr_en;

    // Only the rising edge of Read_Done pops, so a held strobe pops once.
    assign pop_req = Read_Done && !rd_done_q;
    // Pop on an empty FIFO is ignored; there is no write-to-output bypass.
    assign pop_en  = pop_req && (count_q != '0);
    // A pop in the same cycle frees a slot, so a write at full is still accepted.
    assign wr_en   = Rx_Valid && (!full_q || pop_en);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        err_d   = err_q;
        if (wr_en) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_en) begin
            rd_d   = rd_q + AW'(1);
            data_d = mem_q[rd_q][DATA_BITS-1:0];
            err_d  = mem_q[rd_q][EW-1:DATA_BITS];
            ovf_d  = 1'b0;
        end
        if (Rx_Valid && !wr_en) begin
            ovf_d = 1'b1;
        end
        case ({wr_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_done_q <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == CW'(FIFO_DEPTH));
            ovf_q     <= ovf_d;
            rd_done_q <= Read_Done;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // Storage contents are don't-care after reset, so the array is not reset.
    always_ff @(posedge SysClk) begin
        if (wr_en) begin
            mem_q[wr_q] <= {Rx_Error_In, Rx_Data};
        end
    end

    assign Data_Out      = data_q;
    assign Rx_Error      = err_q;
    assign Data_Rdy      = !empty_q;
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = ovf_q;
    assign FIFO_Count    = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       SysClk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx_Valid = 1'b0;
    logic [7:0] Rx_Data = 8'h00;
    logic [2:0] Rx_Error_In = 3'b000;
    logic       Read_Done = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Rdy;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;
    logic [3:0] FIFO_Count;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Rx_Valid      (Rx_Valid),
        .Rx_Data       (Rx_Data),
        .Rx_Error_In   (Rx_Error_In),
        .Read_Done     (Read_Done),
        .Data_Out      (Data_Out),
        .Rx_Error      (Rx_Error),
        .Data_Rdy      (Data_Rdy),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .FIFO_Count    (FIFO_Count)
    );

    always #5 SysClk = ~SysClk;

    // Inputs change on negedge; outputs are sampled on the following negedge.
    task automatic push(input logic [7:0] d, input logic [2:0] e);
        @(negedge SysClk);
        Rx_Valid = 1'b1; Rx_Data = d; Rx_Error_In = e;
        @(negedge SysClk);
        Rx_Valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge SysClk);
        Read_Done = 1'b1;
        @(negedge SysClk);
        Read_Done = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (2) @(negedge SysClk);
        Rst = 1'b1;
        @(negedge SysClk);
        total++; if ({FIFO_Empty, Data_Rdy, FIFO_Full, FIFO_Overflow} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags act=%b exp=1000", {FIFO_Empty, Data_Rdy, FIFO_Full, FIFO_Overflow});
        end
        total++; if ({FIFO_Count, Data_Out, Rx_Error} !== 15'd0) begin
            bad++; $display("FAIL reset_regs cnt=%0d dout=%h err=%b exp zeros", FIFO_Count, Data_Out, Rx_Error);
        end
        // Mid-stream reset: load some state then drop Rst between clock edges.
        push(8'h11, 3'b101);
        push(8'h22, 3'b000);
        push(8'h33, 3'b000);
        pop();
        total++; if (Data_Out !== 8'h11 || Rx_Error !== 3'b101 || FIFO_Count !== 4'd2) begin
            bad++; $display("FAIL pre_reset dout=%h err=%b cnt=%0d exp 11/101/2", Data_Out, Rx_Error, FIFO_Count);
        end
        @(posedge SysClk);
        #2 Rst = 1'b0;
        #1;
        total++; if ({FIFO_Count, Data_Out, Rx_Error} !== 15'd0 ||
                     {FIFO_Empty, Data_Rdy, FIFO_Full, FIFO_Overflow} !== 4'b1000) begin
            bad++; $display("FAIL async_reset cnt=%0d dout=%h err=%b flags=%b exp 0/00/000/1000",
                            FIFO_Count, Data_Out, Rx_Error, {FIFO_Empty, Data_Rdy, FIFO_Full, FIFO_Overflow});
        end
        @(negedge SysClk);
        Rst = 1'b1;
        // Entries written before reset must be gone: popping an empty FIFO holds zeros.
        pop();
        total++; if (Data_Out !== 8'h00 || FIFO_Empty !== 1'b1) begin
            bad++; $display("FAIL reset_discard dout=%h empty=%b exp 00/1", Data_Out, FIFO_Empty);
        end
    endtask

    task automatic test_order();
        for (int i = 0; i < 8; i++) begin
            push(8'(i), 3'(i));
            total++; if (FIFO_Count !== 4'(i + 1)) begin
                bad++; $display("FAIL order_wcnt[%0d] act=%0d exp=%0d", i, FIFO_Count, i + 1);
            end
        end
        total++; if (FIFO_Full !== 1'b1 || FIFO_Empty !== 1'b0 || Data_Rdy !== 1'b1) begin
            bad++; $display("FAIL order_full full=%b empty=%b rdy=%b exp 1/0/1", FIFO_Full, FIFO_Empty, Data_Rdy);
        end
        for (int i = 0; i < 8; i++) begin
            pop();
            total++; if (Data_Out !== 8'(i) || Rx_Error !== 3'(i) || FIFO_Count !== 4'(7 - i)) begin
                bad++; $display("FAIL order_pop[%0d] dout=%h err=%b cnt=%0d exp %h/%b/%0d",
                                i, Data_Out, Rx_Error, FIFO_Count, 8'(i), 3'(i), 7 - i);
            end
        end
        total++; if (FIFO_Empty !== 1'b1 || Data_Rdy !== 1'b0 || FIFO_Full !== 1'b0) begin
            bad++; $display("FAIL order_empty empty=%b rdy=%b full=%b exp 1/0/0", FIFO_Empty, Data_Rdy, FIFO_Full);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push(8'(i), 3'b000);
        push(8'hAA, 3'b111);
        total++; if (FIFO_Overflow !== 1'b1 || FIFO_Count !== 4'd8 || FIFO_Full !== 1'b1) begin
            bad++; $display("FAIL ovf_set ovf=%b cnt=%0d full=%b exp 1/8/1", FIFO_Overflow, FIFO_Count, FIFO_Full);
        end
        pop();
        total++; if (Data_Out !== 8'h00 || FIFO_Overflow !== 1'b0 || FIFO_Count !== 4'd7) begin
            bad++; $display("FAIL ovf_clear dout=%h ovf=%b cnt=%0d exp 00/0/7", Data_Out, FIFO_Overflow, FIFO_Count);
        end
        for (int i = 1; i < 8; i++) begin
            pop();
            total++; if (Data_Out !== 8'(i)) begin
                bad++; $display("FAIL ovf_drain[%0d] act=%h exp=%h", i, Data_Out, 8'(i));
            end
        end
        total++; if (FIFO_Empty !== 1'b1 || Rx_Error !== 3'b000) begin
            bad++; $display("FAIL ovf_dropped empty=%b err=%b exp 1/000", FIFO_Empty, Rx_Error);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 3'b000);
        @(negedge SysClk);
        Rx_Valid = 1'b1; Rx_Data = 8'h55; Rx_Error_In = 3'b001; Read_Done = 1'b1;
        @(negedge SysClk);
        Rx_Valid = 1'b0; Read_Done = 1'b0;
        total++; if (FIFO_Count !== 4'd8 || FIFO_Overflow !== 1'b0 || FIFO_Full !== 1'b1 || Data_Out !== 8'h10) begin
            bad++; $display("FAIL simul_full cnt=%0d ovf=%b full=%b dout=%h exp 8/0/1/10",
                            FIFO_Count, FIFO_Overflow, FIFO_Full, Data_Out);
        end
        for (int i = 1; i < 8; i++) begin
            pop();
            total++; if (Data_Out !== 8'h10 + 8'(i)) begin
                bad++; $display("FAIL simul_drain[%0d] act=%h exp=%h", i, Data_Out, 8'h10 + 8'(i));
            end
        end
        pop();
        total++; if (Data_Out !== 8'h55 || Rx_Error !== 3'b001 || FIFO_Empty !== 1'b1) begin
            bad++; $display("FAIL simul_8th dout=%h err=%b empty=%b exp 55/001/1", Data_Out, Rx_Error, FIFO_Empty);
        end
        // Empty FIFO: pop is ignored, the concurrent write is stored.
        @(negedge SysClk);
        Rx_Valid = 1'b1; Rx_Data = 8'h66; Rx_Error_In = 3'b000; Read_Done = 1'b1;
        @(negedge SysClk);
        Rx_Valid = 1'b0; Read_Done = 1'b0;
        total++; if (FIFO_Count !== 4'd1 || Data_Out !== 8'h55 || FIFO_Empty !== 1'b0) begin
            bad++; $display("FAIL simul_empty cnt=%0d dout=%h empty=%b exp 1/55/0", FIFO_Count, Data_Out, FIFO_Empty);
        end
        pop();
        total++; if (Data_Out !== 8'h66 || FIFO_Count !== 4'd0) begin
            bad++; $display("FAIL simul_empty_pop dout=%h cnt=%0d exp 66/0", Data_Out, FIFO_Count);
        end
    endtask

    task automatic test_errors_edge();
        push(8'hAA, 3'b010);
        push(8'hBB, 3'b100);
        @(negedge SysClk);
        Read_Done = 1'b1;
        repeat (5) @(negedge SysClk);
        total++; if (Data_Out !== 8'hAA || Rx_Error !== 3'b010 || FIFO_Count !== 4'd1) begin
            bad++; $display("FAIL held_pop dout=%h err=%b cnt=%0d exp AA/010/1", Data_Out, Rx_Error, FIFO_Count);
        end
        Read_Done = 1'b0;
        pop();
        total++; if (Data_Out !== 8'hBB || Rx_Error !== 3'b100 || FIFO_Empty !== 1'b1) begin
            bad++; $display("FAIL second_pop dout=%h err=%b empty=%b exp BB/100/1", Data_Out, Rx_Error, FIFO_Empty);
        end
        pop();
        total++; if (Data_Out !== 8'hBB || Rx_Error !== 3'b100 || FIFO_Count !== 4'd0 || FIFO_Overflow !== 1'b0) begin
            bad++; $display("FAIL empty_pop dout=%h err=%b cnt=%0d ovf=%b exp BB/100/0/0",
                            Data_Out, Rx_Error, FIFO_Count, FIFO_Overflow);
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) push(8'(r * 16 + i + 8'h80), 3'(i + r));
            total++; if (FIFO_Count !== 4'd6 || FIFO_Full !== 1'b0) begin
                bad++; $display("FAIL wrap_cnt[%0d] cnt=%0d full=%b exp 6/0", r, FIFO_Count, FIFO_Full);
            end
            for (int i = 0; i < 6; i++) begin
                pop();
                total++; if (Data_Out !== 8'(r * 16 + i + 8'h80) || Rx_Error !== 3'(i + r) ||
                             FIFO_Count !== 4'(5 - i)) begin
                    bad++; $display("FAIL wrap_pop[%0d][%0d] dout=%h err=%b cnt=%0d exp %h/%b/%0d", r, i,
                                    Data_Out, Rx_Error, FIFO_Count, 8'(r * 16 + i + 8'h80), 3'(i + r), 5 - i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_simultaneous();
        test_errors_edge();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
